serial_shifter: RTL and testbench
=================================

# serial_shifter

Parametrised successor to the plain load/shift register: a handshaked serial shift engine that accepts a parallel word, shifts it out one bit at a time (MSB- or LSB-first) at a programmable divided rate, and captures the incoming serial stream into the same register. It presents the captured word on a valid/ready output port. It sits between parallel producers/consumers and bit-serial peripherals (controller pads, serial links), replacing ad-hoc shift registers plus external counters.

## Interface
- WIDTH, 32: shift word width in bits; legal range WIDTH ≥ 2.
- LSB_FIRST, 0: 0 = MSB-first (shift left), 1 = LSB-first (shift right).
- DIVIDE, 1: clock cycles per bit; legal range DIVIDE ≥ 1.

- clk  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- abort  in  1  synchronous; returns the block to IDLE from any state.
- in_valid  in  1  parallel word offered.
- in_ready  out  1  block can accept a word; high only in IDLE.
- data_in  in  WIDTH  parallel word to serialise.
- serial_in  in  1  incoming serial bit, sampled on each shift edge.
- serial_out  out  1  current outgoing bit: sreg[WIDTH-1] (MSB-first) or sreg[0] (LSB-first).
- shift_strobe  out  1  high in the cycle whose closing edge performs a shift.
- busy  out  1  high in SHIFT.
- out_valid  out  1  captured word available; high only in DONE.
- out_ready  in  1  consumer accepts the captured word.
- data_out  out  WIDTH  shift register contents; meaningful while out_valid.

## Operation
- Internal state: FSM {IDLE, SHIFT, DONE}, shift register sreg[WIDTH-1:0], bit counter cnt (0..WIDTH-1, $clog2(WIDTH) bits), divider div (0..DIVIDE-1, max(1,$clog2(DIVIDE)) bits).
- Reset values: state IDLE, sreg 0, cnt 0, div 0. Outputs: in_ready 1, busy 0, out_valid 0, shift_strobe 0, serial_out 0, data_out 0.
- IDLE: in_ready = 1. On in_valid: sreg ← data_in, cnt ← 0, div ← 0, go to SHIFT.
- SHIFT: shift_strobe = (div == DIVIDE-1). If div < DIVIDE-1, div increments.
- SHIFT, shift edge (div == DIVIDE-1):
  - div ← 0.
  - MSB-first: sreg ← {sreg[WIDTH-2:0], serial_in}.
  - LSB-first: sreg ← {serial_in, sreg[WIDTH-1:1]}.
  - If cnt == WIDTH-1, go to DONE; else cnt increments.
- DONE: out_valid = 1; sreg frozen. On out_ready, go to IDLE. in_valid is ignored here.
- abort has priority over every other input. It forces IDLE with cnt, div ← 0; sreg is left unchanged and no output handshake is produced.
- in_valid outside IDLE and out_ready outside DONE have no effect.
- With DIVIDE = 1, shift_strobe is continuously high in SHIFT.

## Timing
- Accept edge E0 is the edge where in_valid && in_ready.
- First shift occurs at E0+DIVIDE; shift k (1..WIDTH) occurs at E0+k·DIVIDE.
- out_valid rises after E0+WIDTH·DIVIDE. Minimum latency (DIVIDE = 1) is WIDTH cycles from accept to out_valid.
- Word throughput: WIDTH·DIVIDE + 2 cycles per word with out_ready held high (1 IDLE cycle, WIDTH·DIVIDE SHIFT cycles, 1 DONE cycle).
- serial_out reflects data_in's first bit in the cycle after E0 and changes only on shift edges. Each bit is held exactly DIVIDE cycles.
- serial_in is sampled only on shift edges; its value at other edges is don't-care.
- reset asserted mid-SHIFT or mid-DONE clears all state immediately, with no wait for a clock edge. After reset deasserts, the first accept follows normal IDLE rules.

## Test plan
- Loopback, WIDTH=8, DIVIDE=1, MSB-first: serial_in = serial_out, load 8'hA5 -> serial_out sequence 1,0,1,0,0,1,0,1; out_valid after E0+8; data_out = 8'hA5.
- LSB-first, WIDTH=8, serial_in tied 1, load 8'h3C -> serial_out sequence 0,0,1,1,1,1,0,0; data_out = 8'hFF; exactly 8 shift_strobe pulses.
- DIVIDE=4, WIDTH=8: shift_strobe pulses every 4th cycle starting at cycle E0+3; out_valid after E0+32; each serial_out bit held 4 cycles.
- Backpressure: out_ready low for 5 cycles in DONE with in_valid high -> out_valid and data_out stable, in_ready 0, no new load. out_ready high -> IDLE next cycle, then accept on the following edge.
- Abort at shift 3 of 8 -> IDLE next cycle, busy 0, out_valid never asserted. A new word is accepted and completes normally with a full 8 shifts.
- Async reset pulse mid-SHIFT between clock edges -> all outputs at reset values immediately, in_ready 1 after release.

Source files
------------

// File: rtl/serial_shifter_if.sv
// serial_shifter_if: parallel/serial handshake bundle for serial_shifter.
interface serial_shifter_if #(parameter int WIDTH = 32);
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic             serial_in;
    logic             serial_out;
    logic             shift_strobe;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    modport master (
        output abort, in_valid, data_in, serial_in, out_ready,
        input  in_ready, serial_out, shift_strobe, busy, out_valid, data_out
    );
    modport slave (
        input  abort, in_valid, data_in, serial_in, out_ready,
        output in_ready, serial_out, shift_strobe, busy, out_valid, data_out
    );
endinterface

// File: rtl/serial_shifter.sv
// serial_shifter: handshaked parallel-to-serial / serial-to-parallel shift engine with bit-rate divider.
module serial_shifter #(
    parameter int WIDTH     = 32,
    parameter int LSB_FIRST = 0,
    parameter int DIVIDE    = 1
) (
    input logic              clk,
    input logic              reset,
    serial_shifter_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int DW = DIVIDE > 1 ? $clog2(DIVIDE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(DIVIDE - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [DW-1:0]    div, div_n;
    logic             strobe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            div   <= '0;
        end else begin
            state <= state_n;
            sreg  <= sreg_n;
            cnt   <= cnt_n;
            div   <= div_n;
        end
    end

    // abort wins over every other input but leaves sreg untouched
    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        cnt_n   = cnt;
        div_n   = div;
        strobe  = state == SHIFT && div == DIV_MAX;
        if (bus.abort) begin
            state_n = IDLE;
            cnt_n   = '0;
            div_n   = '0;
        end else if (state == IDLE) begin
            if (bus.in_valid) begin
                state_n = SHIFT;
                sreg_n  = bus.data_in;
                cnt_n   = '0;
                div_n   = '0;
            end
        end else if (state == SHIFT) begin
            if (strobe) begin
                div_n   = '0;
                sreg_n  = LSB_FIRST != 0 ? {bus.serial_in, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], bus.serial_in};
                state_n = cnt == CNT_MAX ? DONE : SHIFT;
                cnt_n   = cnt == CNT_MAX ? cnt : cnt + 1'b1;
            end else begin
                div_n = div + 1'b1;
            end
        end else if (bus.out_ready) begin
            state_n = IDLE;
        end
    end

    assign bus.in_ready     = state == IDLE;
    assign bus.busy         = state == SHIFT;
    assign bus.out_valid    = state == DONE;
    assign bus.shift_strobe = strobe;
    assign bus.serial_out   = LSB_FIRST != 0 ? sreg[0] : sreg[WIDTH-1];
    assign bus.data_out     = sreg;
endmodule

// File: tb/tb_serial_shifter.sv
// tb_serial_shifter: three 8-bit shifter configurations checked against a bit-position model.
module tb_serial_shifter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       ab[3], iv[3], orr[3], sn[3], lp[3];
    logic [7:0] di[3];
    logic       ir[3], so[3], st[3], bz[3], ov[3];
    logic [7:0] dq[3];
    int divs[3] = '{1, 1, 4};
    int lsbs[3] = '{0, 1, 0};

    serial_shifter_if #(.WIDTH(8)) b0 ();
    serial_shifter_if #(.WIDTH(8)) b1 ();
    serial_shifter_if #(.WIDTH(8)) b2 ();

    serial_shifter #(.WIDTH(8), .LSB_FIRST(0), .DIVIDE(1)) u0 (.clk(clk), .reset(reset), .bus(b0));
    serial_shifter #(.WIDTH(8), .LSB_FIRST(1), .DIVIDE(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
    serial_shifter #(.WIDTH(8), .LSB_FIRST(0), .DIVIDE(4)) u2 (.clk(clk), .reset(reset), .bus(b2));

    assign {b0.abort, b0.in_valid, b0.data_in, b0.out_ready} = {ab[0], iv[0], di[0], orr[0]};
    assign {b1.abort, b1.in_valid, b1.data_in, b1.out_ready} = {ab[1], iv[1], di[1], orr[1]};
    assign {b2.abort, b2.in_valid, b2.data_in, b2.out_ready} = {ab[2], iv[2], di[2], orr[2]};
    assign b0.serial_in = lp[0] ? b0.serial_out : sn[0];
    assign b1.serial_in = lp[1] ? b1.serial_out : sn[1];
    assign b2.serial_in = lp[2] ? b2.serial_out : sn[2];
    assign {ir[0], so[0], st[0], bz[0], ov[0], dq[0]} = {b0.in_ready, b0.serial_out, b0.shift_strobe, b0.busy, b0.out_valid, b0.data_out};
    assign {ir[1], so[1], st[1], bz[1], ov[1], dq[1]} = {b1.in_ready, b1.serial_out, b1.shift_strobe, b1.busy, b1.out_valid, b1.data_out};
    assign {ir[2], so[2], st[2], bz[2], ov[2], dq[2]} = {b2.in_ready, b2.serial_out, b2.shift_strobe, b2.busy, b2.out_valid, b2.data_out};

    int checks = 0;
    int fails = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(int d);
        chk("rst in_ready", ir[d], 1);
        chk("rst busy", bz[d], 0);
        chk("rst out_valid", ov[d], 0);
        chk("rst strobe", st[d], 0);
        chk("rst serial_out", so[d], 0);
        chk("rst data_out", dq[d], 0);
    endtask

    // mode: 0 loopback, 1 serial_in=1, 2 serial_in=0, 3 random serial_in
    task automatic run(int d, logic [7:0] w, int mode, logic [7:0] texp);
        int dv;
        int k;
        int nstr;
        logic eb;
        logic [7:0] cap;
        dv = divs[d];
        nstr = 0;
        cap = '0;
        lp[d] = mode == 0;
        iv[d] = 1'b1;
        di[d] = w;
        chk("in_ready before load", ir[d], 1);
        cyc();
        iv[d] = 1'b0;
        di[d] = 8'($urandom);
        for (int c = 0; c < 8 * dv; c++) begin
            k = c / dv;
            eb = lsbs[d] != 0 ? w[k] : w[7-k];
            sn[d] = mode == 1 ? 1'b1 : mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
            chk("busy in shift", bz[d], 1);
            chk("out_valid in shift", ov[d], 0);
            chk("serial_out", so[d], eb);
            chk("shift_strobe", st[d], c % dv == dv - 1);
            if (st[d]) nstr++;
            if (c % dv == dv - 1) begin
                if (lsbs[d] != 0) cap[k] = mode == 0 ? eb : sn[d];
                else cap[7-k] = mode == 0 ? eb : sn[d];
            end
            cyc();
        end
        chk("out_valid at done", ov[d], 1);
        chk("busy at done", bz[d], 0);
        chk("in_ready at done", ir[d], 0);
        chk("data_out", dq[d], mode == 3 ? cap : texp);
        chk("strobe count", nstr, 8);
        orr[d] = 1'b1;
        cyc();
        orr[d] = 1'b0;
        chk("in_ready after done", ir[d], 1);
        chk("out_valid after done", ov[d], 0);
    endtask

    typedef struct {
        int         d;
        logic [7:0] w;
        int         mode;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[7];
    bit   seen_ov;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 8'hA5, 0, 8'hA5};
        tbl[1] = '{1, 8'h3C, 1, 8'hFF};
        tbl[2] = '{2, 8'hA5, 0, 8'hA5};
        tbl[3] = '{1, 8'h3C, 0, 8'h3C};
        tbl[4] = '{0, 8'h00, 1, 8'hFF};
        tbl[5] = '{2, 8'h81, 2, 8'h00};
        tbl[6] = '{0, 8'h5A, 2, 8'h00};
        for (int d = 0; d < 3; d++) begin
            {ab[d], iv[d], orr[d], sn[d], lp[d], di[d]} = '0;
        end
        cyc();
        cyc();
        for (int d = 0; d < 3; d++) chk_reset_vals(d);
        reset = 1'b0;
        cyc();

        for (int i = 0; i < 7; i++) run(tbl[i].d, tbl[i].w, tbl[i].mode, tbl[i].exp);
        for (int i = 0; i < 9; i++) run(int'($urandom_range(0, 2)), 8'($urandom), 3, 8'h00);

        // backpressure: DONE held with in_valid high and out_ready low
        lp[0] = 1'b0;
        sn[0] = 1'b1;
        iv[0] = 1'b1;
        di[0] = 8'h66;
        cyc();
        for (int i = 0; i < 8; i++) cyc();
        for (int i = 0; i < 5; i++) begin
            chk("bp out_valid", ov[0], 1);
            chk("bp data_out", dq[0], 8'hFF);
            chk("bp in_ready", ir[0], 0);
            cyc();
        end
        orr[0] = 1'b1;
        cyc();
        orr[0] = 1'b0;
        chk("bp idle in_ready", ir[0], 1);
        chk("bp idle out_valid", ov[0], 0);
        cyc();
        chk("bp reload busy", bz[0], 1);
        iv[0] = 1'b0;
        ab[0] = 1'b1;
        cyc();
        ab[0] = 1'b0;
        chk("bp abort in_ready", ir[0], 1);

        // abort in the cycle of shift 3: two shifts done, third suppressed
        lp[0] = 1'b1;
        iv[0] = 1'b1;
        di[0] = 8'hA5;
        cyc();
        iv[0] = 1'b0;
        cyc();
        cyc();
        ab[0] = 1'b1;
        cyc();
        ab[0] = 1'b0;
        chk("abort busy", bz[0], 0);
        chk("abort in_ready", ir[0], 1);
        chk("abort data_out", dq[0], 8'h96);
        seen_ov = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (ov[0]) seen_ov = 1'b1;
            cyc();
        end
        chk("abort no out_valid", seen_ov, 0);
        run(0, 8'hC3, 0, 8'hC3);

        // asynchronous reset pulse between edges mid-SHIFT
        lp[2] = 1'b0;
        iv[2] = 1'b1;
        di[2] = 8'hF0;
        cyc();
        iv[2] = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        chk("pre-reset busy", bz[2], 1);
        #2 reset = 1'b1;
        #1 chk_reset_vals(2);
        #1 reset = 1'b0;
        cyc();
        chk("post-reset in_ready", ir[2], 1);
        run(2, 8'($urandom), 3, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
